// File: rtl/rx_frontend.sv
// rx_frontend: receive-side front end between the ADC pins and the DDC chain.
// Per cycle: channel select/swap/invert, left-justify to 24 bits, per-channel
// DC removal (tracking or frozen offset), IQ magnitude/phase correction, and
// clipped 24-bit I/Q output. Fixed 4-clock latency, no stalls.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   set_stb/addr/data   settings bus (BASE+0 ctrl, +1 I DC, +2 Q DC,
//                       +3 mag_corr, +4 phase_corr)
//   adc_a, adc_b        signed ADC samples, WIDTH_IN bits
//   run                 enables DC tracking updates
//   i_out, q_out        corrected signed 24-bit I/Q, registered
module rx_frontend #(
  parameter int BASE        = 0,
  parameter int WIDTH_IN    = 14,
  parameter int ALPHA_SHIFT = 20,
  parameter int IQCOMP_EN   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_stb,
  input  logic [7:0]          set_addr,
  input  logic [31:0]         set_data,
  input  logic [WIDTH_IN-1:0] adc_a,
  input  logic [WIDTH_IN-1:0] adc_b,
  input  logic                run,
  output logic [23:0]         i_out,
  output logic [23:0]         q_out
);

  localparam int AW = 24 + ALPHA_SHIFT;
  localparam logic [7:0] A_CTRL  = 8'(BASE);
  localparam logic [7:0] A_DCI   = 8'(BASE + 1);
  localparam logic [7:0] A_DCQ   = 8'(BASE + 2);
  localparam logic [7:0] A_MAG   = 8'(BASE + 3);
  localparam logic [7:0] A_PHASE = 8'(BASE + 4);

  // 25-bit signed result clipped to the 24-bit range
  function automatic logic [23:0] clip25(input logic [24:0] v);
    if (v[24] != v[23]) return v[24] ? 24'h800000 : 24'h7FFFFF;
    return v[23:0];
  endfunction

  function automatic logic [23:0] justify(input logic [WIDTH_IN-1:0] s);
    return 24'(s) << (24 - WIDTH_IN);
  endfunction

  // negation that maps the most negative value to the most positive one
  function automatic logic [23:0] sneg(input logic [23:0] v);
    return (v == 24'h800000) ? 24'h7FFFFF : (~v + 24'd1);
  endfunction

  // accumulator add that pins at the accumulator's own limits
  function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a, input logic [23:0] d);
    logic [AW:0] s;
    s = {a[AW-1], a} + {{(AW - 23){d[23]}}, d};
    if (s[AW] != s[AW-1])
      return s[AW] ? {1'b1, {(AW - 1){1'b0}}} : {1'b0, {(AW - 1){1'b1}}};
    return s[AW-1:0];
  endfunction

  // settings and DC loop state
  logic [2:0]    ctrl_q, ctrl_d;
  logic [AW-1:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic          fix_i_q, fix_i_d, fix_q_q, fix_q_d;
  logic [17:0]   mag_q, mag_d, phase_q, phase_d;

  // pipeline
  logic [23:0]   x_i_q, x_i_d, x_q_q, x_q_d;     // S1
  logic [23:0]   d_i_q, d_i_d, d_q_q, d_q_d;     // S2
  logic [23:0]   d1_i_q, d1_q_q;                 // S3 aligned data
  logic [35:0]   pm_q, pm_d, pp_q, pp_d;         // S3 products
  logic [23:0]   out_i_q, out_i_d, out_q_q, out_q_d;

  logic [WIDTH_IN-1:0] a_sel_i, a_sel_q;
  logic [23:0]         off_i, off_q;

  always_comb begin
    ctrl_d  = ctrl_q;
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    fix_i_d = fix_i_q;
    fix_q_d = fix_q_q;
    mag_d   = mag_q;
    phase_d = phase_q;

    if (run && !fix_i_q) acc_i_d = acc_add(acc_i_q, d_i_q);
    if (run && !fix_q_q) acc_q_d = acc_add(acc_q_q, d_q_q);

    // a write to an accumulator overrides that cycle's tracking update
    if (set_stb) begin
      case (set_addr)
        A_CTRL:  ctrl_d = set_data[2:0];
        A_DCI: begin
          acc_i_d = {set_data[23:0], {ALPHA_SHIFT{1'b0}}};
          fix_i_d = set_data[31];
        end
        A_DCQ: begin
          acc_q_d = {set_data[23:0], {ALPHA_SHIFT{1'b0}}};
          fix_q_d = set_data[31];
        end
        A_MAG:   mag_d   = set_data[17:0];
        A_PHASE: phase_d = set_data[17:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    // S1: select, justify, optional saturating inversion
    a_sel_i = ctrl_q[0] ? adc_b : adc_a;
    a_sel_q = ctrl_q[0] ? adc_a : adc_b;
    x_i_d   = justify(a_sel_i);
    x_q_d   = justify(a_sel_q);
    if (ctrl_q[1]) x_i_d = sneg(x_i_d);
    if (ctrl_q[2]) x_q_d = sneg(x_q_d);

    // S2: subtract the integer part of the accumulator
    off_i = acc_i_q[ALPHA_SHIFT+23:ALPHA_SHIFT];
    off_q = acc_q_q[ALPHA_SHIFT+23:ALPHA_SHIFT];
    d_i_d = clip25({x_i_q[23], x_i_q} - {off_i[23], off_i});
    d_q_d = clip25({x_q_q[23], x_q_q} - {off_q[23], off_q});

    // S3: both correction terms are driven by I; zero products give a
    // plain pass-through with identical latency when correction is off
    pm_d = '0;
    pp_d = '0;
    if (IQCOMP_EN != 0) begin
      pm_d = $signed(d_i_q[23:6]) * $signed(mag_q);
      pp_d = $signed(d_i_q[23:6]) * $signed(phase_q);
    end

    // S4
    out_i_d = clip25({d1_i_q[23], d1_i_q} + {pm_q[35], pm_q[35:12]});
    out_q_d = clip25({d1_q_q[23], d1_q_q} + {pp_q[35], pp_q[35:12]});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      fix_i_q <= 1'b0;
      fix_q_q <= 1'b0;
      mag_q   <= '0;
      phase_q <= '0;
      x_i_q   <= '0;
      x_q_q   <= '0;
      d_i_q   <= '0;
      d_q_q   <= '0;
      d1_i_q  <= '0;
      d1_q_q  <= '0;
      pm_q    <= '0;
      pp_q    <= '0;
      out_i_q <= '0;
      out_q_q <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      fix_i_q <= fix_i_d;
      fix_q_q <= fix_q_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
      x_i_q   <= x_i_d;
      x_q_q   <= x_q_d;
      d_i_q   <= d_i_d;
      d_q_q   <= d_q_d;
      d1_i_q  <= d_i_q;
      d1_q_q  <= d_q_q;
      pm_q    <= pm_d;
      pp_q    <= pp_d;
      out_i_q <= out_i_d;
      out_q_q <= out_q_d;
    end
  end

  assign i_out = out_i_q;
  assign q_out = out_q_q;

  logic unused_bits;
  assign unused_bits = ^{set_data[30:24], pm_q[11:0], pp_q[11:0]};

endmodule
